pwm_reg_bank: RTL and testbench

Register bank and PWM generator directly downstream of the SPI slave.
- Consumes the SPI slave's addr/data/write-enable outputs.
- Returns the addressed register's value for SPI reads.
- Drives one PWM output from double-buffered PERIOD/DUTY registers with a selectable prescaler.
- Single clock domain (system clk); SPI signals arrive already synchronous to clk.

---
 rtl/pwm_regs_pkg.sv | 33 +++
 rtl/pwm_counter.sv | 96 +++++++++
 rtl/pwm_reg_bank.sv | 138 +++++++++++++
 tb/tb_pwm_reg_bank.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_regs_pkg.sv
// pwm_regs_pkg
// Shared register-map constants for the PWM register bank and its counter:
//   - register addresses as seen on the SPI addr_reg bus
//   - CTRL bit positions
//   - presc_max(): terminal prescaler count for a CTRL prescale code
// Optional feature macro PWM_IRQ_EN only affects users of CTRL_IRQ_EN/CTRL_IRQ_FLAG.
package pwm_regs_pkg;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PERIOD = 2'd1;
  localparam logic [1:0] ADDR_DUTY   = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  localparam int CTRL_EN        = 0;
  localparam int CTRL_POL       = 1;
  localparam int CTRL_PRESC_LSB = 2;
  localparam int CTRL_PRESC_MSB = 3;
  localparam int CTRL_IRQ_EN    = 4;
  localparam int CTRL_IRQ_FLAG  = 7;

  // Prescale code 0..3 selects divide by 1/2/4/8; tick fires at (2^code)-1.
  function automatic logic [2:0] presc_max(input logic [1:0] sel);
    logic [2:0] m;
    case (sel)
      2'd0:    m = 3'd0;
      2'd1:    m = 3'd1;
      2'd2:    m = 3'd3;
      default: m = 3'd7;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/pwm_counter.sv
// pwm_counter
// Prescaler, 8-bit period counter, double-buffered PERIOD/DUTY shadows and
// the duty compare that produces the registered PWM output.
// Ports:
//   clk, rst_n          system clock, async active-low reset
//   en, pol, presc_sel  CTRL fields (enable, polarity, prescale code)
//   period, duty        programmed register values (shadowed at wrap)
//   pwm_out             registered PWM output
//   cnt                 live counter value (STATUS)
//   wrap                one-clk pulse on every enabled wrap (PWM_IRQ_EN builds only)
module pwm_counter
  import pwm_regs_pkg::*;
#(
  parameter logic [7:0] RST_PERIOD = 8'hFF,
  parameter logic [7:0] RST_DUTY   = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       pol,
  input  logic [1:0] presc_sel,
  input  logic [7:0] period,
  input  logic [7:0] duty,
  output logic       pwm_out,
  output logic [7:0] cnt
`ifdef PWM_IRQ_EN
  ,
  output logic       wrap
`endif
);

  logic [2:0] presc_q, presc_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] period_act_q, period_act_d;
  logic [7:0] duty_act_q, duty_act_d;
  logic       pwm_q, pwm_d;
  logic       tick;
  logic       wrap_s;

  always_comb begin
    presc_d      = presc_q;
    cnt_d        = cnt_q;
    period_act_d = period_act_q;
    duty_act_d   = duty_act_q;
    pwm_d        = pwm_q;
    tick         = 1'b0;
    wrap_s       = 1'b0;
    if (!en) begin
      // Idle: shadows follow the registers so enabling starts with fresh values.
      presc_d      = 3'd0;
      cnt_d        = 8'd0;
      period_act_d = period;
      duty_act_d   = duty;
      pwm_d        = pol;
    end else begin
      // A prescale change simply moves the terminal count; a prescaler already
      // past the new terminal rolls over through 7 before it matches.
      tick    = (presc_q == presc_max(presc_sel));
      presc_d = tick ? 3'd0 : presc_q + 3'd1;
      if (tick) begin
        if (cnt_q == period_act_q) begin
          cnt_d        = 8'd0;
          period_act_d = period;
          duty_act_d   = duty;
          wrap_s       = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      pwm_d = (cnt_q < duty_act_q) ^ pol;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q      <= 3'd0;
      cnt_q        <= 8'd0;
      period_act_q <= RST_PERIOD;
      duty_act_q   <= RST_DUTY;
      pwm_q        <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      cnt_q        <= cnt_d;
      period_act_q <= period_act_d;
      duty_act_q   <= duty_act_d;
      pwm_q        <= pwm_d;
    end
  end

  assign pwm_out = pwm_q;
  assign cnt     = cnt_q;
`ifdef PWM_IRQ_EN
  assign wrap    = wrap_s;
`endif

endmodule

// File: rtl/pwm_reg_bank.sv
// pwm_reg_bank
// SPI-facing register bank (CTRL/PERIOD/DUTY/STATUS) driving one PWM channel.
// Ports:
//   clk, rst_n   system clock, async active-low reset
//   addr_reg     register address from SPI slave
//   data_wr      write data from SPI slave
//   wr_en        write request level; one write per rising edge of wr_en
//   data_rd      combinational read data of the addressed register
//   pwm_out      registered PWM output
//   irq          registered interrupt (only when PWM_IRQ_EN is defined)
// Macro PWM_IRQ_EN adds CTRL[4] irq enable, CTRL[7] sticky wrap flag and irq.
module pwm_reg_bank
  import pwm_regs_pkg::*;
#(
  parameter logic [7:0] RST_PERIOD = 8'hFF,
  parameter logic [7:0] RST_DUTY   = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] addr_reg,
  input  logic [7:0] data_wr,
  input  logic       wr_en,
  output logic [7:0] data_rd,
  output logic       pwm_out
`ifdef PWM_IRQ_EN
  ,
  output logic       irq
`endif
);

  logic [3:0] ctrl_lo_q, ctrl_lo_d;
  logic [7:0] period_q, period_d;
  logic [7:0] duty_q, duty_d;
  logic       wr_en_q, wr_en_d;
  logic       wr_pulse;
  logic [7:0] cnt;
  logic [7:0] ctrl_rd;

  // wr_en is a level that may persist for many clocks; act only on its rise.
  assign wr_pulse = wr_en & ~wr_en_q;

  always_comb begin
    wr_en_d   = wr_en;
    ctrl_lo_d = ctrl_lo_q;
    period_d  = period_q;
    duty_d    = duty_q;
    if (wr_pulse) begin
      case (addr_reg)
        ADDR_CTRL:   ctrl_lo_d = data_wr[CTRL_PRESC_MSB:CTRL_EN];
        ADDR_PERIOD: period_d  = data_wr;
        ADDR_DUTY:   duty_d    = data_wr;
        default:     ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en_q   <= 1'b0;
      ctrl_lo_q <= 4'd0;
      period_q  <= RST_PERIOD;
      duty_q    <= RST_DUTY;
    end else begin
      wr_en_q   <= wr_en_d;
      ctrl_lo_q <= ctrl_lo_d;
      period_q  <= period_d;
      duty_q    <= duty_d;
    end
  end

`ifdef PWM_IRQ_EN
  logic wrap;
  logic irq_en_q, irq_en_d;
  logic irq_flag_q, irq_flag_d;
  logic irq_q, irq_d;
  logic flag_clr;

  always_comb begin
    flag_clr = wr_pulse && (addr_reg == ADDR_CTRL) && data_wr[CTRL_IRQ_FLAG];
    irq_en_d = irq_en_q;
    if (wr_pulse && (addr_reg == ADDR_CTRL)) begin
      irq_en_d = data_wr[CTRL_IRQ_EN];
    end
    // A wrap in the same clock as a clear keeps the flag set.
    irq_flag_d = wrap | (irq_flag_q & ~flag_clr);
    // Registered from next-state values so irq always matches CTRL[7]&CTRL[4].
    irq_d      = irq_flag_d & irq_en_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_en_q   <= 1'b0;
      irq_flag_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      irq_en_q   <= irq_en_d;
      irq_flag_q <= irq_flag_d;
      irq_q      <= irq_d;
    end
  end

  assign irq     = irq_q;
  assign ctrl_rd = {irq_flag_q, 2'b00, irq_en_q, ctrl_lo_q};
`else
  assign ctrl_rd = {4'b0000, ctrl_lo_q};
`endif

  always_comb begin
    data_rd = 8'd0;
    case (addr_reg)
      ADDR_CTRL:   data_rd = ctrl_rd;
      ADDR_PERIOD: data_rd = period_q;
      ADDR_DUTY:   data_rd = duty_q;
      ADDR_STATUS: data_rd = cnt;
      default:     data_rd = 8'd0;
    endcase
  end

  pwm_counter #(
    .RST_PERIOD (RST_PERIOD),
    .RST_DUTY   (RST_DUTY)
  ) u_pwm_counter (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (ctrl_lo_q[CTRL_EN]),
    .pol       (ctrl_lo_q[CTRL_POL]),
    .presc_sel (ctrl_lo_q[CTRL_PRESC_MSB:CTRL_PRESC_LSB]),
    .period    (period_q),
    .duty      (duty_q),
    .pwm_out   (pwm_out),
    .cnt       (cnt)
`ifdef PWM_IRQ_EN
    ,
    .wrap      (wrap)
`endif
  );

endmodule

// File: tb/tb_pwm_reg_bank.sv
// tb_pwm_reg_bank
// Directed self-checking bench for pwm_reg_bank. Expected values are
// hand-computed from the register map and PWM timing; PWM_IRQ_EN builds also
// exercise the sticky wrap flag and irq output.
module tb_pwm_reg_bank;

  logic       clk;
  logic       rst_n;
  logic [1:0] addr_reg;
  logic [7:0] data_wr;
  logic       wr_en;
  logic [7:0] data_rd;
  logic       pwm_out;
`ifdef PWM_IRQ_EN
  logic       irq;
`endif

  int total = 0;
  int bad   = 0;

  pwm_reg_bank #(
    .RST_PERIOD (8'hFF),
    .RST_DUTY   (8'h00)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .addr_reg (addr_reg),
    .data_wr  (data_wr),
    .wr_en    (wr_en),
    .data_rd  (data_rd),
    .pwm_out  (pwm_out)
`ifdef PWM_IRQ_EN
    ,
    .irq      (irq)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    addr_reg = a;
    data_wr  = d;
    wr_en    = 1'b1;
    @(negedge clk);
    wr_en    = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [1:0] a, input logic [7:0] exp);
    addr_reg = a;
    #1;
    check(tag, {24'd0, data_rd}, {24'd0, exp});
  endtask

  task automatic wait_lvl(input logic lvl, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (pwm_out === lvl) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Skip one full active phase so a polarity/config change cannot leave a
  // partial phase in the measurement, then count active and inactive clocks.
  task automatic measure(input logic lvl, output int hi, output int lo);
    bit ok;
    hi = -1;
    lo = -1;
    wait_lvl(~lvl, ok); if (!ok) return;
    wait_lvl(lvl, ok);  if (!ok) return;
    wait_lvl(~lvl, ok); if (!ok) return;
    wait_lvl(lvl, ok);  if (!ok) return;
    hi = 0;
    while (pwm_out === lvl && hi < 300) begin
      hi++;
      @(negedge clk);
    end
    lo = 0;
    while (pwm_out === ~lvl && lo < 300) begin
      lo++;
      @(negedge clk);
    end
  endtask

  task automatic count_high(input int n, output int h);
    h = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (pwm_out === 1'b1) h++;
    end
  endtask

  initial begin
    int  hi, lo, h;
    bit  ok;

    rst_n    = 1'b0;
    addr_reg = 2'd0;
    data_wr  = 8'd0;
    wr_en    = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_pwm_in_reset", {31'd0, pwm_out}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    rd_chk("rst_ctrl",   2'd0, 8'h00);
    rd_chk("rst_period", 2'd1, 8'hFF);
    rd_chk("rst_duty",   2'd2, 8'h00);
    rd_chk("rst_status", 2'd3, 8'h00);
    check("rst_pwm", {31'd0, pwm_out}, 32'd0);

    // Held wr_en: one write only; later data changes are ignored.
    @(negedge clk);
    addr_reg = 2'd1;
    data_wr  = 8'h09;
    wr_en    = 1'b1;
    @(negedge clk);
    rd_chk("wr_visible_next_clk", 2'd1, 8'h09);
    data_wr = 8'h55;
    repeat (18) @(negedge clk);
    rd_chk("wr_held_once", 2'd1, 8'h09);
    wr_en = 1'b0;
    wr(2'd1, 8'h55);
    rd_chk("wr_second_pulse", 2'd1, 8'h55);

    // Write to STATUS ignored; CTRL upper bits.
    wr(2'd3, 8'h77);
    rd_chk("status_wr_ignored", 2'd3, 8'h00);
    rd_chk("status_wr_period_intact", 2'd1, 8'h55);
    wr(2'd0, 8'hF0);
`ifdef PWM_IRQ_EN
    rd_chk("ctrl_upper_bits", 2'd0, 8'h10);
`else
    rd_chk("ctrl_upper_bits", 2'd0, 8'h00);
`endif
    wr(2'd0, 8'h00);

    // Basic PWM: period 10, 3 high.
    wr(2'd1, 8'h09);
    wr(2'd2, 8'h03);
    wr(2'd0, 8'h01);
    measure(1'b1, hi, lo);
    check("pwm_high_clks", hi, 3);
    check("pwm_low_clks", lo, 7);

    wr(2'd0, 8'h03);
    measure(1'b0, hi, lo);
    check("pwm_inv_active_clks", hi, 3);
    check("pwm_inv_idle_clks", lo, 7);

    wr(2'd0, 8'h02);
    @(negedge clk);
    check("disabled_pwm_is_pol", {31'd0, pwm_out}, 32'd1);
    rd_chk("disabled_status_zero", 2'd3, 8'h00);

    // DUTY change mid-period only lands at the next wrap.
    wr(2'd0, 8'h01);
    addr_reg = 2'd3;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (data_rd == 8'd5) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("wait_cnt5", {31'd0, ok}, 32'd1);
    @(negedge clk);
    wr(2'd2, 8'h07);
    addr_reg = 2'd3;
    h = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (pwm_out === 1'b1) h++;
      if (data_rd == 8'd0) break;
      @(negedge clk);
    end
    check("duty_no_mid_period_glitch", h, 0);
    measure(1'b1, hi, lo);
    check("duty7_high_clks", hi, 7);
    check("duty7_low_clks", lo, 3);

    // Div8, period 1, duty 1.
    wr(2'd0, 8'h00);
    wr(2'd1, 8'h01);
    wr(2'd2, 8'h01);
    wr(2'd0, 8'h0D);
    measure(1'b1, hi, lo);
    check("div8_high_clks", hi, 8);
    check("div8_low_clks", lo, 8);

    wr(2'd2, 8'h00);
    repeat (40) @(negedge clk);
    count_high(32, h);
    check("duty0_const_low", h, 0);

    wr(2'd2, 8'hFF);
    repeat (40) @(negedge clk);
    count_high(32, h);
    check("duty_ff_const_high", h, 32);

`ifdef PWM_IRQ_EN
    wr(2'd0, 8'h00);
    wr(2'd1, 8'h03);
    wr(2'd2, 8'h01);
    wr(2'd0, 8'h11);
    repeat (3) @(negedge clk);
    rd_chk("irq_flag_before_wrap", 2'd0, 8'h11);
    @(negedge clk);
    rd_chk("irq_flag_after_4_ticks", 2'd0, 8'h91);
    check("irq_set", {31'd0, irq}, 32'd1);
    repeat (2) @(negedge clk);
    wr(2'd0, 8'h91);
    rd_chk("irq_clear_at_wrap_set_wins", 2'd0, 8'h91);
    check("irq_kept", {31'd0, irq}, 32'd1);
    wr(2'd0, 8'h91);
    rd_chk("irq_flag_cleared", 2'd0, 8'h11);
    check("irq_cleared", {31'd0, irq}, 32'd0);
`endif

    // Async reset mid-period.
    wr(2'd0, 8'h00);
    wr(2'd1, 8'h09);
    wr(2'd2, 8'h05);
    wr(2'd0, 8'h01);
    addr_reg = 2'd0;
    wait_lvl(1'b1, ok);
    check("pre_reset_pwm_high", {31'd0, ok}, 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_pwm", {31'd0, pwm_out}, 32'd0);
    rd_chk("midrst_ctrl",   2'd0, 8'h00);
    rd_chk("midrst_period", 2'd1, 8'hFF);
    rd_chk("midrst_status", 2'd3, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
